// File: rtl/sw_cmd_capture.sv
// Switch/button front end for the ALU core: synchronizes raw inputs, debounces the
// execute button and offers the captured switch byte as a single-entry valid/ready command.
module sw_cmd_capture #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       DIN,
  input  logic             BTN,
  input  logic             CMD_READY,
  output logic             CMD_VALID,
  output logic [7:0]       CMD_DATA,
  output logic [3:0]       CMD_OP,
  output logic [3:0]       CMD_IMM,
  output logic             CMD_ILLEGAL,
  output logic             OVERRUN,
  output logic [CNT_W-1:0] PRESS_CNT
);

  localparam int DB_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [7:0]      din_s1, din_s2;
  logic            btn_s1, btn_s;
  logic            btn_st, btn_st_q;
  logic [DB_W-1:0] db_cnt;
  logic            mismatch;
  logic            press;
  logic            xfer;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      din_s1 <= '0;
      din_s2 <= '0;
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      din_s1 <= DIN;
      din_s2 <= din_s1;
      btn_s1 <= BTN;
      btn_s  <= btn_s1;
    end
  end

  assign mismatch = (btn_s != btn_st);

  // The new level must persist for DB_CYCLES consecutive mismatching cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_st <= 1'b0;
      db_cnt <= '0;
    end else if (!mismatch) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_st <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) btn_st_q <= 1'b0;
    else     btn_st_q <= btn_st;
  end

  // Rising edge of the stable level, built only from flops so it is glitch-free.
  assign press = btn_st & ~btn_st_q;
  assign xfer  = CMD_VALID & CMD_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CMD_VALID <= 1'b0;
      CMD_DATA  <= '0;
      OVERRUN   <= 1'b0;
      PRESS_CNT <= '0;
    end else begin
      if (press && (!CMD_VALID || xfer)) begin
        CMD_VALID <= 1'b1;
        CMD_DATA  <= din_s2;
        PRESS_CNT <= PRESS_CNT + 1'b1;
      end else begin
        if (press) OVERRUN   <= 1'b1;
        if (xfer)  CMD_VALID <= 1'b0;
      end
    end
  end

  assign CMD_OP      = CMD_DATA[7:4];
  assign CMD_IMM     = CMD_DATA[3:0];
  // Opcodes 1..9 are defined; 0 and A..F are not.
  assign CMD_ILLEGAL = (CMD_OP == 4'h0) || (CMD_OP > 4'h9);

endmodule

// File: tb/tb_sw_cmd_capture.sv
// Directed bench for sw_cmd_capture: expected captures go into a scoreboard queue,
// a monitor pops one each time a new command appears on the output.
module tb_sw_cmd_capture;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DIN = '0;
  logic       BTN = 1'b0;
  logic       CMD_READY = 1'b0;
  logic       CMD_VALID;
  logic [7:0] CMD_DATA;
  logic [3:0] CMD_OP;
  logic [3:0] CMD_IMM;
  logic       CMD_ILLEGAL;
  logic       OVERRUN;
  logic [7:0] PRESS_CNT;

  typedef struct {
    logic [7:0] data;
    logic [3:0] op;
    logic [3:0] imm;
    logic       illegal;
    logic [7:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  sw_cmd_capture #(.DB_CYCLES(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .BTN(BTN), .CMD_READY(CMD_READY),
    .CMD_VALID(CMD_VALID), .CMD_DATA(CMD_DATA), .CMD_OP(CMD_OP), .CMD_IMM(CMD_IMM),
    .CMD_ILLEGAL(CMD_ILLEGAL), .OVERRUN(OVERRUN), .PRESS_CNT(PRESS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] op, input logic [3:0] imm,
                      input logic ill, input logic [7:0] c);
    exp_t e;
    e.data = d; e.op = op; e.imm = imm; e.illegal = ill; e.cnt = c;
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic press_release(input logic [7:0] d);
    @(negedge CLK);
    DIN = d;
    BTN = 1'b1;
    repeat (8) @(negedge CLK);
    BTN = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic ready_pulse();
    @(negedge CLK);
    CMD_READY = 1'b1;
    @(negedge CLK);
    CMD_READY = 1'b0;
  endtask

  // Monitor: a new command is a rising CMD_VALID or a PRESS_CNT change while valid.
  logic       pv = 1'b0;
  logic [7:0] pc = '0;
  always @(negedge CLK) begin
    if (RST) begin
      pv = 1'b0;
      pc = '0;
    end else begin
      if (CMD_VALID && (!pv || PRESS_CNT != pc)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_cmd", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_data", CMD_DATA, e.data);
          chk("sb_op", CMD_OP, e.op);
          chk("sb_imm", CMD_IMM, e.imm);
          chk("sb_illegal", CMD_ILLEGAL, e.illegal);
          chk("sb_cnt", PRESS_CNT, e.cnt);
        end
      end
      pv = CMD_VALID;
      pc = PRESS_CNT;
    end
  end

  initial begin
    int edge_seen;
    #1;
    chk("rst_valid", CMD_VALID, 0);
    chk("rst_data", CMD_DATA, 8'h00);
    chk("rst_illegal", CMD_ILLEGAL, 1);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_cnt", PRESS_CNT, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // 1: latency and capture of 0x1D
    DIN = 8'h1D;
    repeat (3) @(negedge CLK);
    push(8'h1D, 4'h1, 4'hD, 1'b0, 8'd1);
    BTN = 1'b1;
    edge_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK);
      #1;
      if (k == 5) BTN = 1'b0;
      if (CMD_VALID && edge_seen == 0) edge_seen = k;
    end
    chk("latency_edge", edge_seen, 7);
    chk("t1_cnt", PRESS_CNT, 1);

    // 2: transfer, then release produces nothing
    @(negedge CLK);
    CMD_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("t2_valid_fall", CMD_VALID, 0);
    chk("t2_data_hold", CMD_DATA, 8'h1D);
    CMD_READY = 1'b0;
    repeat (15) @(negedge CLK);
    chk("t2_no_release_cmd", CMD_VALID, 0);
    chk("t2_cnt", PRESS_CNT, 1);

    // 3: 3-cycle glitch is rejected
    @(negedge CLK);
    DIN = 8'h33;
    BTN = 1'b1;
    repeat (3) @(negedge CLK);
    BTN = 1'b0;
    repeat (12) @(negedge CLK);
    chk("t3_valid", CMD_VALID, 0);
    chk("t3_cnt", PRESS_CNT, 1);

    // 4: press while pending -> overrun
    do_reset();
    push(8'h40, 4'h4, 4'h0, 1'b0, 8'd1);
    press_release(8'h40);
    press_release(8'h50);
    chk("t4_data", CMD_DATA, 8'h40);
    chk("t4_overrun", OVERRUN, 1);
    chk("t4_cnt", PRESS_CNT, 1);
    ready_pulse();
    chk("t4_valid", CMD_VALID, 0);
    chk("t4_overrun_sticky", OVERRUN, 1);

    // 5: transfer and press on the same edge
    do_reset();
    push(8'h60, 4'h6, 4'h0, 1'b0, 8'd1);
    press_release(8'h60);
    @(negedge CLK);
    DIN = 8'h70;
    push(8'h70, 4'h7, 4'h0, 1'b0, 8'd2);
    BTN = 1'b1;
    for (int k = 1; k <= 6; k++) @(posedge CLK);
    #1;
    CMD_READY = 1'b1;
    @(posedge CLK);
    #1;
    CMD_READY = 1'b0;
    chk("t5_valid", CMD_VALID, 1);
    chk("t5_data", CMD_DATA, 8'h70);
    chk("t5_overrun", OVERRUN, 0);
    chk("t5_cnt", PRESS_CNT, 2);
    repeat (4) @(negedge CLK);
    BTN = 1'b0;
    repeat (10) @(negedge CLK);
    ready_pulse();

    // 6: illegal opcode, counter wrap, async reset
    do_reset();
    push(8'hA0, 4'hA, 4'h0, 1'b1, 8'd1);
    press_release(8'hA0);
    chk("t6_illegal", CMD_ILLEGAL, 1);
    do_reset();
    CMD_READY = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      logic [7:0] d;
      logic [7:0] c;
      d = 8'(i * 7);
      c = 8'(i);
      push(d, d[7:4], d[3:0], (d[7:4] == 4'h0) || (d[7:4] > 4'h9), c);
      press_release(d);
    end
    CMD_READY = 1'b0;
    chk("t6_wrap_cnt", PRESS_CNT, 0);
    push(8'h35, 4'h3, 4'h5, 1'b0, 8'd1);
    press_release(8'h35);
    chk("t6_pending", CMD_VALID, 1);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("async_valid", CMD_VALID, 0);
    chk("async_data", CMD_DATA, 0);
    chk("async_cnt", PRESS_CNT, 0);
    chk("async_overrun", OVERRUN, 0);
    chk("async_illegal", CMD_ILLEGAL, 1);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
